// File: rtl/common_lru_pkg.sv
// ============================================================================
// Module   : common_lru_pkg
// Purpose  : Heap-index helpers and bit polarity shared by the PLRU blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package common_lru_pkg;

  localparam logic PLRU_LEFT  = 1'b0;
  localparam logic PLRU_RIGHT = 1'b1;

  function automatic int unsigned heap_parent(input int unsigned n);
    return n >> 1;
  endfunction

  function automatic int unsigned heap_left(input int unsigned n);
    return n << 1;
  endfunction

  function automatic int unsigned heap_right(input int unsigned n);
    return (n << 1) | 32'd1;
  endfunction

  // Depth of a heap node; the root (node 1) is level 0.
  function automatic int unsigned heap_level(input int unsigned n);
    int unsigned lvl;
    lvl = 0;
    for (int i = 1; i < 32; i++) begin
      if ((n >> i) != 0) lvl = i;
    end
    return lvl;
  endfunction

  function automatic int unsigned leaf_to_way(input int unsigned leaf, input int unsigned levels);
    return leaf - (32'd1 << levels);
  endfunction

  function automatic int unsigned way_to_leaf(input int unsigned way, input int unsigned levels);
    return (32'd1 << levels) + way;
  endfunction

endpackage

`default_nettype wire

// File: rtl/common_pseudo_lru_set_binwr_if.sv
// ============================================================================
// Module   : common_pseudo_lru_set_binwr_if
// Purpose  : Touch / query / clear bundle of the multi-set PLRU tracker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface common_pseudo_lru_set_binwr_if #(
  parameter int SUBJECT_COUNT_LOG2 = 2,
  parameter int SET_COUNT_LOG2     = 2
);
  localparam int P_COUNT = 1 << SUBJECT_COUNT_LOG2;
  localparam int SET_W   = (SET_COUNT_LOG2 > 0) ? SET_COUNT_LOG2 : 1;

  logic                          clear;
  logic                          touch_en;
  logic [SET_W-1:0]              touch_set;
  logic [SUBJECT_COUNT_LOG2-1:0] touch_way;
  logic                          q_en;
  logic [SET_W-1:0]              q_set;
  logic [P_COUNT-1:0]            q_dvalid;
  logic [P_COUNT-1:0]            q_lock;
  logic                          q_valid;
  logic [SUBJECT_COUNT_LOG2-1:0] q_way;
  logic                          q_none;

  modport master (
    output clear, touch_en, touch_set, touch_way, q_en, q_set, q_dvalid, q_lock,
    input  q_valid, q_way, q_none
  );

  modport slave (
    input  clear, touch_en, touch_set, touch_way, q_en, q_set, q_dvalid, q_lock,
    output q_valid, q_way, q_none
  );

endinterface

`default_nettype wire

// File: rtl/common_pseudo_lru_tree_pick.sv
// ============================================================================
// Module   : common_pseudo_lru_tree_pick
// Purpose  : Combinational lock-aware PLRU walk from root to victim leaf.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module common_pseudo_lru_tree_pick
  import common_lru_pkg::*;
#(
  parameter int SUBJECT_COUNT_LOG2 = 2
) (
  input  logic [(1<<SUBJECT_COUNT_LOG2)-1:1] tree,
  input  logic [(1<<SUBJECT_COUNT_LOG2)-1:0] lock,
  output logic [SUBJECT_COUNT_LOG2-1:0]      way,
  output logic                               none
);

  localparam int WAY_W   = SUBJECT_COUNT_LOG2;
  localparam int P_COUNT = 1 << SUBJECT_COUNT_LOG2;

  // True when every way under the given heap node is locked.
  function automatic logic subtree_locked(input logic [P_COUNT-1:0] lk, input int unsigned node);
    int unsigned lvl;
    int unsigned first;
    int unsigned span;
    logic        all;
    lvl   = heap_level(node);
    first = leaf_to_way(node << (WAY_W - lvl), WAY_W);
    span  = 32'd1 << (WAY_W - lvl);
    all   = 1'b1;
    for (int unsigned i = 0; i < P_COUNT; i++) begin
      if (i >= first && i < first + span && !lk[i]) all = 1'b0;
    end
    return all;
  endfunction

  always_comb begin : p_walk
    int unsigned node;
    int unsigned pref;
    int unsigned alt;
    logic        dir;
    node = 1;
    pref = 0;
    alt  = 0;
    dir  = PLRU_LEFT;
    for (int l = 0; l < WAY_W; l++) begin
      dir = PLRU_LEFT;
      for (int unsigned n = 1; n < P_COUNT; n++) begin
        if (n == node) dir = tree[n];
      end
      pref = (dir == PLRU_RIGHT) ? heap_right(node) : heap_left(node);
      alt  = (dir == PLRU_RIGHT) ? heap_left(node)  : heap_right(node);
      node = subtree_locked(lock, pref) ? alt : pref;
    end
    none = &lock;
    way  = none ? '0 : WAY_W'(leaf_to_way(node, WAY_W));
  end

endmodule

`default_nettype wire

// File: rtl/macro_encoder_onehot_bin.sv
// ============================================================================
// Module   : macro_encoder_onehot_bin
// Purpose  : One-hot to binary encoder (OR of the indices of set bits).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module macro_encoder_onehot_bin #(
  parameter int ONEHOT_WIDTH = 4,
  parameter int BIN_WIDTH    = (ONEHOT_WIDTH > 1) ? $clog2(ONEHOT_WIDTH) : 1
) (
  input  logic [ONEHOT_WIDTH-1:0] onehot,
  output logic [BIN_WIDTH-1:0]    bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < ONEHOT_WIDTH; i++) begin
      if (onehot[i]) bin = bin | BIN_WIDTH'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/common_pseudo_lru_set_binwr.sv
// ============================================================================
// Module   : common_pseudo_lru_set_binwr
// Purpose  : Per-set tree PLRU tracker with registered invalid-first,
//            lock-aware victim query and write-first touch forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module common_pseudo_lru_set_binwr
  import common_lru_pkg::*;
#(
  parameter int SUBJECT_COUNT_LOG2 = 2,
  parameter int SET_COUNT_LOG2     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  common_pseudo_lru_set_binwr_if.slave bus
);

  localparam int WAY_W   = SUBJECT_COUNT_LOG2;
  localparam int P_COUNT = 1 << SUBJECT_COUNT_LOG2;
  localparam int S_COUNT = 1 << SET_COUNT_LOG2;
  localparam int SET_W   = (SET_COUNT_LOG2 > 0) ? SET_COUNT_LOG2 : 1;

  // Every ancestor of the touched leaf is pointed at its other child.
  function automatic logic [P_COUNT-1:1] touch_apply(input logic [P_COUNT-1:1] tree,
                                                     input logic [WAY_W-1:0]   way);
    logic [P_COUNT-1:1] t;
    int unsigned        leaf;
    int unsigned        lvl;
    t    = tree;
    leaf = way_to_leaf(32'(way), WAY_W);
    for (int unsigned n = 1; n < P_COUNT; n++) begin
      lvl = heap_level(n);
      if ((leaf >> (WAY_W - lvl)) == n)
        t[n] = ((leaf >> (WAY_W - lvl - 1)) == heap_left(n)) ? PLRU_RIGHT : PLRU_LEFT;
    end
    return t;
  endfunction

  logic [P_COUNT-1:1] r_tree [S_COUNT];
  logic [P_COUNT-1:1] w_eff  [S_COUNT];
  logic [P_COUNT-1:1] w_q_tree;

  // w_eff is both the next stored state and the tree the query sees.
  always_comb begin
    w_q_tree = '0;
    for (int s = 0; s < S_COUNT; s++) begin
      w_eff[s] = r_tree[s];
      if (bus.clear)
        w_eff[s] = '0;
      else if (bus.touch_en && bus.touch_set == SET_W'(s))
        w_eff[s] = touch_apply(r_tree[s], bus.touch_way);
      if (bus.q_set == SET_W'(s)) w_q_tree = w_eff[s];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < S_COUNT; s++) r_tree[s] <= '0;
    end else begin
      for (int s = 0; s < S_COUNT; s++) r_tree[s] <= w_eff[s];
    end
  end

  logic [P_COUNT-1:0] w_free;
  logic [P_COUNT-1:0] w_free_low;
  logic [WAY_W-1:0]   w_free_way;
  logic [WAY_W-1:0]   w_tree_way;
  logic               w_tree_none;
  logic [WAY_W-1:0]   w_pick_way;
  logic               w_pick_none;

  assign w_free     = ~bus.q_dvalid & ~bus.q_lock;
  assign w_free_low = w_free & (~w_free + P_COUNT'(1));

  macro_encoder_onehot_bin #(
    .ONEHOT_WIDTH (P_COUNT),
    .BIN_WIDTH    (WAY_W)
  ) u_free_enc (
    .onehot (w_free_low),
    .bin    (w_free_way)
  );

  common_pseudo_lru_tree_pick #(
    .SUBJECT_COUNT_LOG2 (SUBJECT_COUNT_LOG2)
  ) u_tree_pick (
    .tree (w_q_tree),
    .lock (bus.q_lock),
    .way  (w_tree_way),
    .none (w_tree_none)
  );

  always_comb begin
    w_pick_way  = w_tree_way;
    w_pick_none = w_tree_none;
    if (|w_free) begin
      w_pick_way  = w_free_way;
      w_pick_none = 1'b0;
    end
  end

  logic             r_q_valid;
  logic [WAY_W-1:0] r_q_way;
  logic             r_q_none;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q_valid <= 1'b0;
      r_q_way   <= '0;
      r_q_none  <= 1'b0;
    end else begin
      r_q_valid <= bus.q_en;
      if (bus.q_en) begin
        r_q_way  <= w_pick_way;
        r_q_none <= w_pick_none;
      end
    end
  end

  assign bus.q_valid = r_q_valid;
  assign bus.q_way   = r_q_way;
  assign bus.q_none  = r_q_none;

endmodule

`default_nettype wire

// File: doc/common_pseudo_lru_set_binwr.md
Name: common_pseudo_lru_set_binwr

Overview:
- Multi-set tree pseudo-LRU replacement tracker with binary-encoded set, way and pick ports. Successor to the single-set binary PLRU picker.
- Holds one PLRU tree per set for set-associative caches and TLBs.
- Adds the following, which the single-set picker does not have:
  - per-set state;
  - a registered query port;
  - an invalid-first pick from the per-query valid mask;
  - a way-lock mask for pinned lines;
  - same-cycle touch forwarding;
  - a global clear.

Parameters:
- SUBJECT_COUNT_LOG2, 2, log2 of ways per set; must be >=1. P_COUNT = 1<<SUBJECT_COUNT_LOG2.
- SET_COUNT_LOG2, 2, log2 of set count; must be >=0. S_COUNT = 1<<SET_COUNT_LOG2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all trees.
- touch_en  in  1  access update strobe.
- touch_set  in  max(SET_COUNT_LOG2,1)  set being touched.
- touch_way  in  SUBJECT_COUNT_LOG2  way being touched (most recently used).
- q_en  in  1  victim query strobe.
- q_set  in  max(SET_COUNT_LOG2,1)  set being queried.
- q_dvalid  in  P_COUNT  valid bit per way of the queried set.
- q_lock  in  P_COUNT  1 = way must not be picked.
- q_valid  out  1  pick result valid.
- q_way  out  SUBJECT_COUNT_LOG2  picked victim way.
- q_none  out  1  all ways locked, no victim available.

Behaviour:
- State:
  - Per set, a tree of P_COUNT-1 bits in heap indexing: node 1 is the root; node n has children 2n and 2n+1; leaves map to ways 0..P_COUNT-1, left to right.
  - Node bit 0 = victim lies in the left (lower-index) subtree; 1 = right.
- Reset (reset=0, async): all tree bits 0; q_valid=0, q_way=0, q_none=0.
- clear=1: all tree bits 0 at the next edge. It has priority over a same-cycle touch_en. A query in that cycle sees the cleared (all-0) state.
- Touch, when touch_en=1:
  - For every node on the path to touch_way, set the bit to point away from touch_way: 1 if touch_way is in the node's left subtree, else 0.
  - Off-path bits and other sets are unchanged.
  - Takes effect at the next edge.
- Query, when q_en=1: the result is registered with 1-cycle latency. At the next edge q_valid=1 and q_way/q_none are updated. When q_en=0, q_valid=0 at the next edge and q_way/q_none hold their previous values.
- Pick priority, evaluated combinationally on the effective tree:
  1. Lowest-index way with q_dvalid=0 and q_lock=0 → q_way=that way, q_none=0.
  2. Otherwise walk from the root and follow the node bit. If the followed subtree is fully locked, take the sibling subtree. The leaf reached → q_way, q_none=0.
  3. If q_lock is all ones → q_none=1, q_way=0, q_valid=1.
- Effective tree:
  - If touch_en=1 and touch_set==q_set in the same cycle, the pick uses the tree with that touch already applied (write-first forwarding).
  - Otherwise it uses the stored tree.
- A simultaneous touch and query to different sets are independent.
- q_dvalid and q_lock are sampled only in the q_en cycle. They are not stored.
- Out-of-range inputs: none are possible, since all encodings cover the full power-of-two ranges.
- Reset asserted mid-query drops q_valid immediately, asynchronously.

Decomposition:
- Shared package (common_lru_pkg) holds:
  - heap-index helper functions: parent, left/right child, and leaf-to-way mapping;
  - PLRU bit polarity constants (PLRU_LEFT=0, PLRU_RIGHT=1).
- One sub-module, common_pseudo_lru_tree_pick: combinational lock-aware walk taking (tree bits, lock mask) and producing (way, none).
- The touch-update logic and the state array stay in the top module.
- The invalid-first priority encoder reuses macro_encoder_onehot_bin on the isolated lowest-set bit.

Test Plan (SUBJECT_COUNT_LOG2=2, SET_COUNT_LOG2=2):
1. Reset release; q_en set=0, dvalid=4'hF, lock=0 → next cycle q_valid=1, q_way=0, q_none=0.
2. Touch set0 way0; query → way2. Touch set0 way2; query → way1. Query set1 → way0 (set isolation).
3. Tree state pointing to way2; query with dvalid=4'b1011, lock=0 → way2. dvalid=4'b0011, lock=4'b0100 → way3.
4. After reset, dvalid=4'hF, lock=4'b0011 → way2. lock=4'hF → q_none=1, q_way=0, q_valid=1.
5. Same cycle: touch set1 way0 and query set1 → way2 (forwarded). Touch set2 way0 with a query on set3 → set3 result way0.
6. Several touches, then clear=1 together with touch set0 way0 → subsequent query set0 → way0. Assert reset mid-query → q_valid=0 immediately and trees all 0.
